// File: rtl/test_seq.sv
// Test vector sequencer: issues LFSR operand pairs and qualifies monitor mismatch events.
// Optional TEST_SEQ_STOP_ON_ERR_EN: stop issuing on the first qualified mismatch, then drain.
//
// Handshake: o_vld high means o_dut_ia/o_dut_ib carry a new vector this cycle. The consumer
// cannot stall it. i_event is meaningful only EVT_LAT cycles after a vector was issued.
module test_seq #(
  parameter int WIDTH   = 32,
  parameter int EVT_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [31:0]      i_num_tests,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_dut_ia,
  output logic [WIDTH-1:0] o_dut_ib,
  output logic             o_vld,
  input  logic [WIDTH-1:0] i_event,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_err_cnt,
  output logic [31:0]      o_first_fail_idx,
  output logic             o_first_fail_vld,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] TAPS       = 32'h80200003;
  localparam logic [WIDTH-1:0] LFSR_ONE   = 32'h00000001;
  localparam logic [4:0]       DRAIN_LAST = 5'(EVT_LAT - 1);

  state_t           state;
  logic [WIDTH-1:0] lfsr_a;
  logic [WIDTH-1:0] lfsr_b;
  logic [WIDTH-1:0] lfsr_a_nxt;
  logic [WIDTH-1:0] lfsr_b_nxt;
  logic [WIDTH-1:0] seed_a;
  logic [WIDTH-1:0] seed_b;
  logic [31:0]      issue_cnt;
  logic [31:0]      num_tests;
  logic [4:0]       drain_cnt;
  logic             pipe_vld [EVT_LAT];
  logic [31:0]      pipe_idx [EVT_LAT];
  logic             evt_hit;
  logic             last_issue;
  logic             stop_req;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  assign lfsr_a_nxt = lfsr_step(lfsr_a);
  assign lfsr_b_nxt = lfsr_step(lfsr_b);
  // All-zero is the LFSR lock-up state, so it is replaced by 1.
  assign seed_a     = (i_seed == '0) ? LFSR_ONE : i_seed;
  assign seed_b     = (~i_seed == '0) ? LFSR_ONE : ~i_seed;
  assign evt_hit    = pipe_vld[EVT_LAT-1] && (i_event != '0);
  assign last_issue = (issue_cnt + 32'd1 == num_tests);
  assign o_state    = state;

`ifdef TEST_SEQ_STOP_ON_ERR_EN
  assign stop_req = evt_hit;
`else
  assign stop_req = 1'b0;
`endif

  // Delay line pairing each issued vector with the cycle its event is due.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < EVT_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= o_vld;
      pipe_idx[0] <= issue_cnt;
      for (int i = 1; i < EVT_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      o_vld            <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_err_cnt        <= '0;
      o_first_fail_idx <= '0;
      o_first_fail_vld <= 1'b0;
      o_dut_ia         <= '0;
      o_dut_ib         <= '0;
      lfsr_a           <= LFSR_ONE;
      lfsr_b           <= LFSR_ONE;
      issue_cnt        <= '0;
      num_tests        <= '0;
      drain_cnt        <= '0;
    end else begin
      if (evt_hit) begin
        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 32'd1;
        if (!o_first_fail_vld) begin
          o_first_fail_vld <= 1'b1;
          o_first_fail_idx <= pipe_idx[EVT_LAT-1];
        end
      end

      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            // Assignments here override the event update above on a restart.
            o_err_cnt        <= '0;
            o_first_fail_vld <= 1'b0;
            o_first_fail_idx <= '0;
            issue_cnt        <= '0;
            num_tests        <= i_num_tests;
            lfsr_a           <= seed_a;
            lfsr_b           <= seed_b;
            o_dut_ia         <= seed_a;
            o_dut_ib         <= seed_b;
            if (i_num_tests == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state  <= RUN;
              o_vld  <= 1'b1;
              o_busy <= 1'b1;
              o_done <= 1'b0;
            end
          end
        end

        RUN: begin
          issue_cnt <= issue_cnt + 32'd1;
          lfsr_a    <= lfsr_a_nxt;
          lfsr_b    <= lfsr_b_nxt;
          o_dut_ia  <= lfsr_a_nxt;
          o_dut_ib  <= lfsr_b_nxt;
          if (last_issue || stop_req) begin
            state     <= DRAIN;
            o_vld     <= 1'b0;
            drain_cnt <= '0;
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 5'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_seq.sv
// Bench for test_seq: directed and randomized runs checked against an LFSR/queue model
// of the issued vectors, mismatch counting and completion timing.
module tb_test_seq;

  localparam int          WIDTH   = 32;
  localparam int          EVT_LAT = 5;
  localparam logic [31:0] TAPS    = 32'h80200003;
`ifdef TEST_SEQ_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             i_start = 1'b0;
  logic [31:0]      i_num_tests = '0;
  logic [WIDTH-1:0] i_seed = '0;
  logic [WIDTH-1:0] i_event = '0;
  logic [WIDTH-1:0] o_dut_ia;
  logic [WIDTH-1:0] o_dut_ib;
  logic             o_vld;
  logic             o_busy;
  logic             o_done;
  logic [31:0]      o_err_cnt;
  logic [31:0]      o_first_fail_idx;
  logic             o_first_fail_vld;
  logic [1:0]       o_state;

  int checks = 0;
  int errors = 0;

  logic [2*WIDTH-1:0] exp_q[$];
  int                 hist[$];
  bit                 err_set[int];
  int                 vec_idx;
  int                 run_cyc;
  int                 vld_first;
  int                 vld_last;
  logic [31:0]        first_a;
  logic [31:0]        first_b;

  test_seq #(.WIDTH(WIDTH), .EVT_LAT(EVT_LAT)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (i_start),
    .i_num_tests      (i_num_tests),
    .i_seed           (i_seed),
    .o_dut_ia         (o_dut_ia),
    .o_dut_ib         (o_dut_ib),
    .o_vld            (o_vld),
    .i_event          (i_event),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err_cnt        (o_err_cnt),
    .o_first_fail_idx (o_first_fail_idx),
    .o_first_fail_vld (o_first_fail_vld),
    .o_state          (o_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] ref_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor: scoreboard the issued vector and drive this cycle's event.
  task automatic monitor_step();
    logic [2*WIDTH-1:0] e;
    int                 due;
    if (o_vld) begin
      if (exp_q.size() == 0) begin
        check("extra_vld", {31'h0, o_vld}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("ia[%0d]", vec_idx), o_dut_ia, e[63:32]);
        check($sformatf("ib[%0d]", vec_idx), o_dut_ib, e[31:0]);
      end
      if (vec_idx == 0) begin
        first_a = o_dut_ia;
        first_b = o_dut_ib;
      end
      if (vld_first < 0) vld_first = run_cyc;
      vld_last = run_cyc;
      hist.push_back(vec_idx);
      vec_idx++;
    end else begin
      hist.push_back(-1);
    end
    due = -1;
    if (hist.size() > EVT_LAT) due = hist.pop_front();
    if (due >= 0) i_event = err_set.exists(due) ? ($urandom() | 32'h1) : 32'h0;
    else          i_event = ($urandom_range(0, 3) == 0) ? ($urandom() | 32'h1) : 32'h0;
  endtask

  task automatic tick();
    @(negedge clk);
    run_cyc++;
    monitor_step();
  endtask

  task automatic fill_exp(input int count, input logic [31:0] seed);
    logic [31:0] a;
    logic [31:0] b;
    a = ref_seed(seed);
    b = ref_seed(~seed);
    exp_q.delete();
    for (int i = 0; i < count; i++) begin
      exp_q.push_back({a, b});
      a = ref_step(a);
      b = ref_step(b);
    end
  endtask

  task automatic begin_run(input int n, input logic [31:0] seed);
    hist.delete();
    vec_idx      = 0;
    run_cyc      = 0;
    vld_first    = -1;
    vld_last     = -1;
    i_num_tests  = n;
    i_seed       = seed;
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
    i_num_tests  = $urandom();
    i_seed       = $urandom();
  endtask

  // One full run; poke>0 pulses i_start at that cycle to confirm it is ignored while busy.
  task automatic run_test(input string name, input int n, input logic [31:0] seed, input int poke);
    int f;
    int issued;
    int exp_errs;
    int exp_done;
    logic [31:0] hold_err;
    f = -1;
    foreach (err_set[k]) if (k < n && (f < 0 || k < f)) f = k;
    issued = n;
    if (STOP_ON_ERR && f >= 0 && f + EVT_LAT + 1 < n) issued = f + EVT_LAT + 1;
    exp_errs = 0;
    foreach (err_set[k]) if (k < issued) exp_errs++;
    exp_done = (n == 0) ? 1 : issued + 1 + EVT_LAT;

    fill_exp(issued, seed);
    begin_run(n, seed);
    while (!o_done && run_cyc < exp_done + 20) begin
      i_start = (run_cyc == poke);
      tick();
    end
    i_start = 1'b0;

    check({name, ".done_cycle"}, run_cyc, exp_done);
    check({name, ".vectors"}, vec_idx, issued);
    check({name, ".left_in_q"}, exp_q.size(), 0);
    check({name, ".vld_first"}, vld_first, (issued > 0) ? 1 : -1);
    check({name, ".vld_last"}, vld_last, (issued > 0) ? issued : -1);
    check({name, ".err_cnt"}, o_err_cnt, exp_errs);
    check({name, ".first_vld"}, {31'h0, o_first_fail_vld}, (f >= 0 && f < issued) ? 1 : 0);
    if (f >= 0 && f < issued) check({name, ".first_idx"}, o_first_fail_idx, f);
    check({name, ".busy"}, {31'h0, o_busy}, 0);
    hold_err = o_err_cnt;
    repeat (3) tick();
    check({name, ".done_hold"}, {31'h0, o_done}, 1);
    check({name, ".err_hold"}, o_err_cnt, hold_err);
    check({name, ".state_done"}, {30'h0, o_state}, 3);
  endtask

  initial begin
    int n;
    int done_seen;
    // Reset
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst.vld", {31'h0, o_vld}, 0);
    check("rst.busy", {31'h0, o_busy}, 0);
    check("rst.done", {31'h0, o_done}, 0);
    check("rst.err_cnt", o_err_cnt, 0);
    check("rst.first_idx", o_first_fail_idx, 0);
    check("rst.first_vld", {31'h0, o_first_fail_vld}, 0);
    check("rst.ia", o_dut_ia, 0);
    check("rst.ib", o_dut_ib, 0);
    check("rst.state", {30'h0, o_state}, 0);

    // Clean run of 10
    err_set.delete();
    run_test("basic", 10, 32'h1, 0);

    // Seed zero, 100 vectors
    run_test("seed0", 100, 32'h0, 0);
    check("seed0.first_ia", first_a, 32'h00000001);
    check("seed0.first_ib", first_b, 32'hFFFFFFFF);

    // Mismatches on 3 and 7, with an ignored restart pulse mid-run
    err_set.delete();
    err_set[3] = 1'b1;
    err_set[7] = 1'b1;
    run_test("err37", 10, 32'hDEADBEEF, 4);

    // Early mismatch in a long run (stops early when the option is built in)
    err_set.delete();
    err_set[2] = 1'b1;
    run_test("err2", 50, 32'h12345678, 0);

    // Zero-length run and all-ones seed
    err_set.delete();
    run_test("zero", 0, 32'h5, 0);
    run_test("ones", 8, 32'hFFFFFFFF, 0);
    check("ones.first_ib", first_b, 32'h00000001);

    // Reset on the 4th RUN cycle, together with i_start
    fill_exp(10, 32'hA5A5A5A5);
    begin_run(10, 32'hA5A5A5A5);
    repeat (3) tick();
    reset   = 1'b1;
    i_start = 1'b1;
    tick();
    check("abort.state", {30'h0, o_state}, 0);
    check("abort.vld", {31'h0, o_vld}, 0);
    check("abort.busy", {31'h0, o_busy}, 0);
    check("abort.err_cnt", o_err_cnt, 0);
    check("abort.first_vld", {31'h0, o_first_fail_vld}, 0);
    check("abort.ia", o_dut_ia, 0);
    reset   = 1'b0;
    i_start = 1'b0;
    done_seen = 0;
    repeat (20) begin
      tick();
      if (o_done) done_seen++;
    end
    check("abort.no_done", done_seen, 0);
    check("abort.idle", {30'h0, o_state}, 0);
    exp_q.delete();
    err_set.delete();
    run_test("after_abort", 10, 32'h1, 0);

    // Randomized runs
    for (int r = 0; r < 5; r++) begin
      err_set.delete();
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) if ($urandom_range(0, 5) == 0) err_set[k] = 1'b1;
      run_test($sformatf("rand%0d", r), n, $urandom(), $urandom_range(2, n + 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/test_seq.md
TEST_SEQ -- requirements
Module: test_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter EVT_LAT, default 5, cycles from a vector issued on o_vld to its qualified event at i_event; legal range 1..16.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  one-cycle pulse that begins a run; sampled only in IDLE or DONE.
REQ-006 i_num_tests  input  32  number of vectors to issue; sampled when i_start is accepted.
REQ-007 i_seed  input  WIDTH  LFSR seed; sampled when i_start is accepted.
REQ-008 o_dut_ia  output  WIDTH  operand A to the DUT and monitor.
REQ-009 o_dut_ib  output  WIDTH  operand B to the DUT and monitor.
REQ-010 o_vld  output  1  o_dut_ia/o_dut_ib carry a new test vector this cycle.
REQ-011 i_event  input  WIDTH  monitor mismatch event; any nonzero value is a mismatch.
REQ-012 o_busy  output  1  high in RUN and DRAIN.
REQ-013 o_done  output  1  high in DONE.
REQ-014 o_err_cnt  output  32  qualified mismatches in the current run; saturates at 0xFFFFFFFF.
REQ-015 o_first_fail_idx  output  32  index of the vector that produced the first mismatch (0-based).
REQ-016 o_first_fail_vld  output  1  o_first_fail_idx is valid.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE/DONE + i_start: go to RUN; clear o_err_cnt, o_first_fail_vld and the issue counter; load the LFSRs.
REQ-019 i_start with i_num_tests=0: go directly to DONE with zero counts and no o_vld.
REQ-020 RUN: o_vld is high every cycle; exactly i_num_tests vectors are issued on consecutive cycles.
REQ-021 RUN to DRAIN: on the cycle after the last vector is issued.
REQ-022 DRAIN: o_vld is low; exit to DONE once EVT_LAT cycles after the last vector have elapsed, so that every issued vector has been qualified.
REQ-023 DONE: hold all results until the next accepted i_start; i_start in RUN or DRAIN is ignored.
REQ-024 Operand LFSR A is a 32-bit Galois LFSR with taps 0x80200003, loaded with i_seed; a seed of 0 loads 0x00000001.
REQ-025 Operand LFSR B uses the same polynomial and is loaded with ~i_seed; a value of 0 loads 0x00000001.
REQ-026 Both LFSRs advance once per issued vector; o_dut_ia/o_dut_ib show the current state of each LFSR when o_vld is high.
REQ-027 An EVT_LAT-deep shift register of o_vld, carrying the vector index, qualifies i_event; an unqualified i_event is ignored.
REQ-028 A qualified nonzero i_event increments o_err_cnt.
REQ-029 On the first qualified mismatch, set o_first_fail_vld and capture the index; later mismatches do not overwrite it.
REQ-030 A qualified event in the same cycle as the last issue or the DRAIN exit is still counted.
REQ-031 The vector index wraps modulo 2^32.

Reset
REQ-032 Reset returns the FSM to IDLE.
REQ-033 Reset clears o_vld, o_busy, o_done, o_err_cnt, o_first_fail_idx, o_first_fail_vld, the qualifying pipeline and the LFSRs (to 0x00000001); o_dut_ia/o_dut_ib reset to 0.
REQ-034 Reset asserted mid-RUN or mid-DRAIN aborts the run without a DONE; reset takes priority over i_start.

Configuration
REQ-035 Macro TEST_SEQ_STOP_ON_ERR_EN defined: the first qualified mismatch in RUN drops o_vld from the next cycle, and the FSM goes to DRAIN; later events still count.
REQ-036 Macro TEST_SEQ_STOP_ON_ERR_EN undefined: mismatches never alter sequencing, and all i_num_tests vectors are issued.

Verification
REQ-037 Reset, then i_start with i_num_tests=10, seed=0x1, i_event=0 -> 10 consecutive o_vld; o_done 10+1+EVT_LAT cycles after start; o_err_cnt=0; o_first_fail_vld=0.
REQ-038 Seed=0 -> first o_dut_ia=0x00000001 and first o_dut_ib=0xFFFFFFFF; the sequence matches the reference LFSR model for 100 vectors.
REQ-039 i_event nonzero for vector indices 3 and 7 (without the macro), i_num_tests=10 -> o_err_cnt=2, o_first_fail_idx=3, and all 10 vectors issued.
REQ-040 With TEST_SEQ_STOP_ON_ERR_EN, a mismatch on index 2 and i_num_tests=50 -> o_vld stops within one cycle; o_first_fail_idx=2; DONE is reached after the drain.
REQ-041 i_num_tests=0 -> o_done the cycle after start, and o_vld never asserts.
REQ-042 Reset at the 4th cycle of RUN, then a new start -> state IDLE, counters 0, no o_done; the new run behaves as in REQ-037.
